// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - single-request sequencer for a two-phase multiplexed external memory bus
module mem_bus_ctrl #(
  parameter int BITS         = 8,
  parameter int TIMEOUT      = 15,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_rom_ram,
  input  logic            req_we,
  input  logic [BITS-1:0] req_addr,
  input  logic [BITS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [BITS-1:0] rsp_data,
  output logic            rsp_err,
  output logic [BITS-1:0] bus_out,
  input  logic [BITS-1:0] bus_in,
  output logic            bus_oe,
  output logic            bus_rom_ram,
  output logic            bus_addr_data,
  output logic            bus_we,
  input  logic            bus_ack
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state, state_nxt;
  logic [BITS-1:0]         addr_q, wdata_q;
  logic                    we_q, rom_ram_q;
  logic [TIMEOUT_BITS-1:0] cnt;
  logic                    timed_out;

  // Wait counter saturates at TIMEOUT, so it never wraps.
  assign timed_out = (cnt == TIMEOUT_BITS'(TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and Moore-decoded handshake/bus outputs.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    bus_oe        = 1'b0;
    bus_we        = 1'b0;
    bus_addr_data = 1'b0;
    bus_rom_ram   = 1'b0;
    bus_out       = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Writes to ROM are refused without touching the bus.
          state_nxt = (req_we && !req_rom_ram) ? RESP : ADDR;
        end
      end
      ADDR: begin
        bus_out       = addr_q;
        bus_oe        = 1'b1;
        bus_addr_data = 1'b1;
        bus_rom_ram   = rom_ram_q;
        state_nxt     = DATA;
      end
      DATA: begin
        bus_rom_ram = rom_ram_q;
        if (we_q) begin
          bus_out = wdata_q;
          bus_oe  = 1'b1;
          bus_we  = 1'b1;
        end
        if (bus_ack || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rom_ram_q <= 1'b0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            we_q      <= req_we;
            rom_ram_q <= req_rom_ram;
            if (req_we && !req_rom_ram) begin
              rsp_data <= '1;
              rsp_err  <= 1'b1;
            end
          end
        end
        ADDR: cnt <= '0;
        DATA: begin
          // An ack arriving on the final wait cycle still counts as success.
          if (bus_ack) begin
            rsp_data <= we_q ? '0 : bus_in;
            rsp_err  <= 1'b0;
          end else if (timed_out) begin
            rsp_data <= '1;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
